regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised integer register file for the RISC-V core, generalising the fixed 32x32, 2-read/1-write register bank.
- Configurable data width, register count and read-port count.
- Synchronous clear.
- Optional write-to-read bypass.
- Per-register pending-write scoreboard (busy bits), so decode can stall on multi-cycle results (loads, mul/div).
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2); AW = clog2(NREGS)
NRD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  out  NRD  1 = register addressed by port k has a pending write
we  in  1  write enable
wa  in  AW  write address
wd  in  XLEN  write data
iss_en  in  1  mark register iss_rd as pending (instruction issued with long latency)
iss_rd  in  AW  register to mark busy
busy_cnt  out  clog2(NREGS)+1  number of registers currently busy
any_busy  out  1  busy_cnt != 0

Behaviour:
- Reset: on a rising clk with rst=1:
  - all NREGS registers <= 0; all busy bits <= 0; busy_cnt = 0, any_busy = 0.
  - Writes and issues in that cycle are ignored.
- Write: on a rising clk with rst=0 and we=1, Register[wa] <= wd.
  - Suppressed when ZERO_REG=1 and wa=0.
- Read: rd_data[k] = Register[rd_addr[k]], combinational, zero latency.
  - ZERO_REG=1 and rd_addr[k]=0 -> 0, regardless of stored state, bypass or busy.
- Bypass (BYPASS=1): when rst=0, we=1, wa==rd_addr[k] and wa is a writable register, then rd_data[k]=wd and rd_busy[k]=0 in the same cycle.
  - BYPASS=0 -> new value visible from the cycle after the edge.
  - rst=1 disables bypass.
- Scoreboard, one busy bit per register, updated on the rising edge with rst=0:
  - we=1 clears busy[wa].
  - iss_en=1 sets busy[iss_rd].
  - iss_en and we on the same register in the same cycle: set wins (new producer in flight; the write still updates data).
  - iss_en on an already-busy register: stays busy; no counting of outstanding producers.
  - Register 0 is never set when ZERO_REG=1.
  - we to a non-busy register: data written, busy unchanged (0).
- rd_busy[k] = busy[rd_addr[k]], except cleared by bypass as above.
- busy_cnt: registered popcount of the busy bits, updated in the same edge as the bits.
  - Range 0..NREGS (NREGS only possible when ZERO_REG=0).
  - Must never wrap.
- Reset mid-operation: busy bits are dropped with no completion; any later we to a formerly busy register simply writes data.
- Multiple read ports on the same address return identical data and busy.
- Out-of-range addresses are impossible (AW exact).

Decomposition:
- Shared package (rv_pkg): XLEN default, REG_ZERO constant, a register-address type sized by AW.
- One sub-module is natural: regfile_scoreboard.
  - Contents: busy vector, set/clear priority, popcount register.
  - Ports: clk, rst, set_en/set_addr, clr_en/clr_addr, busy vector out, busy_cnt.
- Data array and read/bypass muxing stay in regfile_param, built with generate loops over NRD.

Test Plan:
1. Reset clear: fill all regs with 0xA5A5_0000+i, assert rst one cycle -> every rd_data=0, busy_cnt=0, any_busy=0.
2. x0 protection: we=1, wa=0, wd=0xDEADBEEF, iss_en=1 iss_rd=0 -> reading port0 addr0 gives 0, rd_busy=0, busy_cnt=0.
3. Bypass: we=1 wa=5 wd=0x12345678, rd_addr[1]=5 in the same cycle.
   - BYPASS=1 -> rd_data[1]=0x12345678 in that cycle.
   - BYPASS=0 -> old value that cycle, new value next cycle.
4. Scoreboard lifecycle:
   - iss_en to x7 -> next cycle rd_busy=1, busy_cnt=1.
   - 3 cycles later we wa=7 wd=0x55 -> busy clears at the edge, rd_data=0x55, busy_cnt=0.
5. Simultaneous set/clear: x9 busy; same cycle we wa=9 wd=0x1 and iss_en iss_rd=9 -> data=0x1, x9 remains busy, busy_cnt unchanged.
6. Parameter sweep: NREGS=16, XLEN=64, NRD=3, ZERO_REG=0.
   - Issue all 16 registers -> busy_cnt=16.
   - Write x0=0xFFFF_FFFF_FFFF_FFFF -> readable on all 3 ports, busy_cnt=15.
   - rst mid-sequence -> busy_cnt=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the integer register file.
//   XLEN_DEFAULT : default data width of the core
//   NREGS_DEF    : default architectural register count
//   REG_ZERO     : index of the hardwired-zero register
//   reg_addr_t   : register address type for the default register count
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREGS_DEF    = 32;
    localparam int REG_ZERO     = 0;
    localparam int AW_DEF       = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count of busy registers.
//   clk, rst          : clock, synchronous active-high reset
//   set_en, set_addr  : mark a register busy (producer issued)
//   clr_en, clr_addr  : clear a register's busy bit (result written back)
//   busy              : busy vector, bit i = register i pending
//   busy_cnt          : number of busy registers, same edge as the bits
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter  int NREGS    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS),
    localparam int CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    // Clear is applied before set so that a new producer issued in the
    // same cycle as an older result's writeback keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
    end

    // Count is taken from the next-state vector so it lands on the same
    // edge as the bits; CW bits hold NREGS without wrapping.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised integer register file with combinational read ports,
// optional write-to-read bypass and a pending-write scoreboard.
//   clk, rst  : clock, synchronous active-high reset (clears data and busy)
//   rd_addr   : NRD read addresses, port k at [k*AW +: AW]
//   rd_data   : NRD read data, port k at [k*XLEN +: XLEN]
//   rd_busy   : per-port busy flag of the addressed register
//   we/wa/wd  : writeback port; also clears the busy bit of wa
//   iss_en/iss_rd : mark iss_rd busy (long-latency producer issued)
//   busy_cnt  : registered number of busy registers
//   any_busy  : busy_cnt != 0
module regfile_param
    import rv_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic [AW:0]         busy_cnt,
    output logic                any_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_ok;

    // A write lands unless it targets the hardwired-zero register.
    assign wr_ok = (ZERO_REG == 0) || (wa != AW'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wr_ok) begin
            regs[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_en),
        .set_addr (iss_rd),
        .clr_en   (we),
        .clr_addr (wa),
        .busy     (busy_vec),
        .busy_cnt (busy_cnt)
    );

    assign any_busy = (busy_cnt != '0);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            is_zero;
        logic            hit;
        logic [XLEN-1:0] rdata;
        logic            rbusy;

        assign addr    = rd_addr[k*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == AW'(REG_ZERO));
        // Bypass forwards the in-flight write; the write also retires the
        // pending producer, so the port reports not-busy.
        assign hit     = (BYPASS != 0) && !rst && we && wr_ok && (wa == addr);

        always_comb begin
            rdata = regs[addr];
            rbusy = busy_vec[addr];
            if (is_zero) begin
                rdata = '0;
                rbusy = 1'b0;
            end else if (hit) begin
                rdata = wd;
                rbusy = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = rdata;
        assign rd_busy[k]              = rbusy;
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    // ---------------- clock / reset ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT A: defaults (32x32, 2 ports, zero reg, bypass)
    logic         a_rst, a_we, a_iss;
    logic [9:0]   a_rd_addr;
    logic [4:0]   a_wa, a_iss_rd;
    logic [31:0]  a_wd;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [5:0]   a_cnt;
    logic         a_any;

    // DUT B: 16x64, 3 ports, no zero reg, no bypass
    logic         b_rst, b_we, b_iss;
    logic [11:0]  b_rd_addr;
    logic [3:0]   b_wa, b_iss_rd;
    logic [63:0]  b_wd;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic [4:0]   b_cnt;
    logic         b_any;

    regfile_param dut_a (
        .clk(clk), .rst(a_rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .we(a_we), .wa(a_wa), .wd(a_wd),
        .iss_en(a_iss), .iss_rd(a_iss_rd), .busy_cnt(a_cnt), .any_busy(a_any)
    );

    regfile_param #(
        .XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(b_rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .we(b_we), .wa(b_wa), .wd(b_wd),
        .iss_en(b_iss), .iss_rd(b_iss_rd), .busy_cnt(b_cnt), .any_busy(b_any)
    );

    // ---------------- reference model ----------------
    logic [63:0] ma_regs [32];
    bit          ma_busy [32];
    logic [63:0] mb_regs [16];
    bit          mb_busy [16];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // What a read port must show, from the architectural rules.
    function automatic logic [63:0] ref_read(bit zr, bit byp, bit rst, bit we, int wa,
                                             logic [63:0] wd, int addr, logic [63:0] stored);
        if (zr && addr == 0) return 64'h0;
        if (byp && !rst && we && wa == addr && !(zr && wa == 0)) return wd;
        return stored;
    endfunction

    function automatic bit ref_busy(bit zr, bit byp, bit rst, bit we, int wa, int addr, bit stored);
        if (zr && addr == 0) return 1'b0;
        if (byp && !rst && we && wa == addr && !(zr && wa == 0)) return 1'b0;
        return stored;
    endfunction

    function automatic int count_a();
        int n = 0;
        foreach (ma_busy[i]) n += ma_busy[i];
        return n;
    endfunction

    function automatic int count_b();
        int n = 0;
        foreach (mb_busy[i]) n += mb_busy[i];
        return n;
    endfunction

    task automatic model_reset_all();
        for (int i = 0; i < 32; i++) begin ma_regs[i] = '0; ma_busy[i] = 0; end
        for (int i = 0; i < 16; i++) begin mb_regs[i] = '0; mb_busy[i] = 0; end
    endtask

    task automatic model_edge();
        if (a_rst) begin
            for (int i = 0; i < 32; i++) begin ma_regs[i] = '0; ma_busy[i] = 0; end
        end else begin
            if (a_we && a_wa != 0) ma_regs[a_wa] = {32'h0, a_wd};
            if (a_we) ma_busy[a_wa] = 0;
            if (a_iss && a_iss_rd != 0) ma_busy[a_iss_rd] = 1;
        end
        if (b_rst) begin
            for (int i = 0; i < 16; i++) begin mb_regs[i] = '0; mb_busy[i] = 0; end
        end else begin
            if (b_we) begin mb_regs[b_wa] = b_wd; mb_busy[b_wa] = 0; end
            if (b_iss) mb_busy[b_iss_rd] = 1;
        end
    endtask

    // Check every output of both DUTs against the model, then advance one edge.
    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            int ad;
            ad = int'(a_rd_addr[k*5 +: 5]);
            check($sformatf("a_data%0d", k), {32'h0, a_rd_data[k*32 +: 32]},
                  ref_read(1, 1, a_rst, a_we, int'(a_wa), {32'h0, a_wd}, ad, ma_regs[ad]));
            check($sformatf("a_busy%0d", k), {63'h0, a_rd_busy[k]},
                  {63'h0, ref_busy(1, 1, a_rst, a_we, int'(a_wa), ad, ma_busy[ad])});
        end
        check("a_cnt", {58'h0, a_cnt}, 64'(count_a()));
        check("a_any", {63'h0, a_any}, {63'h0, count_a() != 0});
        for (int k = 0; k < 3; k++) begin
            int ad;
            ad = int'(b_rd_addr[k*4 +: 4]);
            check($sformatf("b_data%0d", k), b_rd_data[k*64 +: 64],
                  ref_read(0, 0, b_rst, b_we, int'(b_wa), b_wd, ad, mb_regs[ad]));
            check($sformatf("b_busy%0d", k), {63'h0, b_rd_busy[k]},
                  {63'h0, ref_busy(0, 0, b_rst, b_we, int'(b_wa), ad, mb_busy[ad])});
        end
        check("b_cnt", {59'h0, b_cnt}, 64'(count_b()));
        check("b_any", {63'h0, b_any}, {63'h0, count_b() != 0});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_a();
        a_rst = 0; a_we = 0; a_iss = 0;
        a_wa = 5'($urandom); a_wd = $urandom; a_iss_rd = 5'($urandom);
        a_rd_addr = 10'($urandom);
    endtask

    task automatic idle_b();
        b_rst = 0; b_we = 0; b_iss = 0;
        b_wa = 4'($urandom); b_wd = {$urandom, $urandom}; b_iss_rd = 4'($urandom);
        b_rd_addr = 12'($urandom);
    endtask

    task automatic rand_a();
        a_rst = ($urandom_range(0, 40) == 0);
        a_we = $urandom_range(0, 1); a_iss = ($urandom_range(0, 2) == 0);
        a_wa = 5'($urandom_range(0, 15)); a_iss_rd = 5'($urandom_range(0, 15));
        a_wd = $urandom;
        a_rd_addr = 10'($urandom);
        if ($urandom_range(0, 3) == 0) a_rd_addr[4:0] = a_wa;
        if ($urandom_range(0, 3) == 0) a_rd_addr[9:5] = a_wa;
        if ($urandom_range(0, 3) == 0) a_rd_addr[9:5] = a_rd_addr[4:0];
    endtask

    task automatic rand_b();
        b_rst = ($urandom_range(0, 40) == 0);
        b_we = $urandom_range(0, 1); b_iss = ($urandom_range(0, 1) == 0);
        b_wa = 4'($urandom); b_iss_rd = 4'($urandom);
        b_wd = {$urandom, $urandom};
        b_rd_addr = 12'($urandom);
        if ($urandom_range(0, 3) == 0) b_rd_addr[3:0] = b_wa;
        if ($urandom_range(0, 3) == 0) b_rd_addr[11:8] = b_rd_addr[3:0];
    endtask

    // ---------------- test sequence ----------------
    initial begin
        a_rst = 1; b_rst = 1;
        a_we = 0; a_iss = 0; a_wa = '0; a_wd = '0; a_iss_rd = '0; a_rd_addr = '0;
        b_we = 0; b_iss = 0; b_wa = '0; b_wd = '0; b_iss_rd = '0; b_rd_addr = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset_all();

        // Reset state, still under reset
        tick();
        idle_a(); idle_b();

        // 1. Fill, then reset clears everything
        for (int i = 0; i < 32; i++) begin
            a_we = 1; a_wa = 5'(i); a_wd = 32'hA5A5_0000 + i;
            a_iss = (i % 3 == 0); a_iss_rd = 5'(i);
            tick();
        end
        idle_a();
        a_rd_addr = {5'd31, 5'd17};
        #1;
        check("t1_fill17", {32'h0, a_rd_data[31:0]}, 64'hA5A5_0011);
        tick();
        a_rst = 1; a_we = 1; a_wa = 5'd3; a_iss = 1; a_iss_rd = 5'd4;
        tick();
        idle_a();
        for (int i = 0; i < 16; i++) begin
            a_rd_addr = {5'(2 * i + 1), 5'(2 * i)};
            #1;
            check("t1_clr", {32'h0, a_rd_data[31:0]} | {32'h0, a_rd_data[63:32]}, 64'h0);
            tick();
        end
        check("t1_cnt", {58'h0, a_cnt}, 64'h0);

        // 2. Register 0 protection
        a_we = 1; a_wa = 5'd0; a_wd = 32'hDEAD_BEEF; a_iss = 1; a_iss_rd = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        tick();
        idle_a(); a_rd_addr = {5'd0, 5'd0};
        #1;
        check("t2_x0", {32'h0, a_rd_data[31:0]}, 64'h0);
        check("t2_x0busy", {63'h0, a_rd_busy[0]}, 64'h0);
        check("t2_cnt", {58'h0, a_cnt}, 64'h0);
        tick();

        // 3. Bypass on A, no bypass on B
        b_we = 1; b_wa = 4'd5; b_wd = 64'h1111;
        tick();
        a_we = 1; a_wa = 5'd5; a_wd = 32'h1234_5678; a_rd_addr = {5'd5, 5'd1};
        b_we = 1; b_wa = 4'd5; b_wd = 64'h1234_5678; b_rd_addr = {4'd0, 4'd5, 4'd0};
        #1;
        check("t3_byp", {32'h0, a_rd_data[63:32]}, 64'h1234_5678);
        check("t3_nobyp_old", b_rd_data[127:64], 64'h1111);
        tick();
        idle_a(); idle_b(); b_rd_addr = {4'd0, 4'd5, 4'd0};
        #1;
        check("t3_nobyp_new", b_rd_data[127:64], 64'h1234_5678);
        tick();

        // 4. Scoreboard lifecycle on x7
        a_iss = 1; a_iss_rd = 5'd7;
        tick();
        idle_a(); a_rd_addr = {5'd0, 5'd7};
        #1;
        check("t4_busy", {63'h0, a_rd_busy[0]}, 64'h1);
        check("t4_cnt1", {58'h0, a_cnt}, 64'h1);
        for (int i = 0; i < 3; i++) tick();
        a_we = 1; a_wa = 5'd7; a_wd = 32'h55;
        tick();
        idle_a(); a_rd_addr = {5'd0, 5'd7};
        #1;
        check("t4_data", {32'h0, a_rd_data[31:0]}, 64'h55);
        check("t4_cnt0", {58'h0, a_cnt}, 64'h0);
        tick();

        // 5. Simultaneous set and clear on x9
        a_iss = 1; a_iss_rd = 5'd9;
        tick();
        a_iss = 1; a_iss_rd = 5'd9; a_we = 1; a_wa = 5'd9; a_wd = 32'h1;
        tick();
        idle_a(); a_rd_addr = {5'd9, 5'd9};
        #1;
        check("t5_data", {32'h0, a_rd_data[63:32]}, 64'h1);
        check("t5_busy", {63'h0, a_rd_busy[1]}, 64'h1);
        check("t5_cnt", {58'h0, a_cnt}, 64'h1);
        tick();

        // 6. Wide config: fill scoreboard, write x0, reset mid-sequence
        for (int i = 0; i < 16; i++) begin
            b_iss = 1; b_iss_rd = 4'(i);
            tick();
        end
        idle_b();
        check("t6_cnt16", {59'h0, b_cnt}, 64'd16);
        b_we = 1; b_wa = 4'd0; b_wd = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle_b(); b_rd_addr = 12'h000;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("t6_x0p%0d", k), b_rd_data[k*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_cnt15", {59'h0, b_cnt}, 64'd15);
        tick();
        b_rst = 1;
        tick();
        idle_b();
        check("t6_rstcnt", {59'h0, b_cnt}, 64'd0);
        b_we = 1; b_wa = 4'd3; b_wd = 64'hABCD;
        tick();
        idle_b();

        // Randomized traffic on both configurations
        for (int n = 0; n < 600; n++) begin
            rand_a(); rand_b();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
